// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared types and constants for the SPI command decoder.
//   opcode_t : the four legal command opcodes held in bits [7:5] of the first byte
//   state_t  : decoder FSM states
package spi_cmd_pkg;

  localparam int OPCODE_MSB = 7;
  localparam int OPCODE_LSB = 5;

  typedef enum logic [2:0] {
    OP_WRITE_AT   = 3'b100,
    OP_READ_AT    = 3'b101,
    OP_WRITE_NEXT = 3'b110,
    OP_READ_NEXT  = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    DATA,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/spi_cmd_if.sv
// spi_cmd_if: single-byte request bus between the command decoder and the
// system bus arbiter.
//   bus_addr, bus_wr_data, bus_rw_n (1=read), bus_strobe : request, master -> slave
//   bus_done, bus_rd_data                                : completion, slave -> master
interface spi_cmd_if #(
  parameter int ADDR_WIDTH = 17
);
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [7:0]            bus_wr_data;
  logic                  bus_rw_n;
  logic                  bus_strobe;
  logic                  bus_done;
  logic [7:0]            bus_rd_data;

  modport master (
    output bus_addr, bus_wr_data, bus_rw_n, bus_strobe,
    input  bus_done, bus_rd_data
  );

  modport slave (
    input  bus_addr, bus_wr_data, bus_rw_n, bus_strobe,
    output bus_done, bus_rd_data
  );
endinterface

// File: rtl/spi_cmd_sync2.sv
// sync2: N-flop synchronizer bringing an asynchronous level into clk_sys.
//   clk_sys, reset : system clock, synchronous active-high reset
//   d              : asynchronous input
//   q              : synchronized output (N cycles of latency); N must be >= 2
module sync2 #(
  parameter int   N         = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_sys) begin
    if (reset) ff <= {N{RESET_VAL}};
    else       ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/spi_cmd.sv
// spi_cmd: parses 1-4 byte SPI commands arriving from the SCLK-domain byte
// receiver and issues single-byte read/write requests to the bus arbiter.
//   clk_sys, reset      : system clock (>= 8x SCLK), synchronous active-high reset
//   spi_cs_n, spi_valid : asynchronous chip select / byte-valid (synchronized here)
//   spi_rx              : received byte, stable while spi_valid is high
//   spi_tx              : last read result, shifted back out by the receiver
//   busy                : high from bus_strobe until bus_done
//   cmd_error           : sticky illegal-opcode flag, cleared on CS falling edge
//   bus                 : request bus to the arbiter (master side)
module spi_cmd
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       spi_cs_n,
  input  logic       spi_valid,
  input  logic [7:0] spi_rx,
  output logic [7:0] spi_tx,
  output logic       busy,
  output logic       cmd_error,
  spi_cmd_if.master  bus
);

  logic cs_s, valid_s, cs_prev, valid_prev;
  logic cs_fall, cs_rise, byte_evt;

  // CS idles high, so its synchronizer resets high to avoid a false frame start.
  sync2 #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_sys(clk_sys), .reset(reset), .d(spi_cs_n), .q(cs_s)
  );
  sync2 #(.N(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_valid (
    .clk_sys(clk_sys), .reset(reset), .d(spi_valid), .q(valid_s)
  );

  assign cs_fall  = cs_prev & ~cs_s;
  assign cs_rise  = ~cs_prev & cs_s;
  assign byte_evt = valid_s & ~valid_prev;

  // Byte is captured on byte_evt and decoded one cycle later from rx_q.
  logic [7:0] rx_q;
  logic       byte_rdy;

  state_t                state, state_n;
  logic                  is_read, is_read_n;
  logic                  go_idle, go_idle_n;     // CS edge seen during a bus cycle
  logic [ADDR_WIDTH-1:0] addr_stage, addr_stage_n;
  logic [7:0]            data_stage, data_stage_n;
  logic [7:0]            spi_tx_n;
  logic                  busy_n, cmd_error_n, issue;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n      = state;
    is_read_n    = is_read;
    go_idle_n    = go_idle;
    addr_stage_n = addr_stage;
    data_stage_n = data_stage;
    spi_tx_n     = spi_tx;
    busy_n       = busy;
    cmd_error_n  = cmd_error;

    case (state)
      IDLE: if (byte_rdy) begin
        if (!rx_q[OPCODE_MSB]) begin
          cmd_error_n = 1'b1;
          state_n     = DONE;
        end else begin
          case (opcode_t'(rx_q[OPCODE_MSB:OPCODE_LSB]))
            OP_WRITE_AT, OP_READ_AT: begin
              is_read_n        = rx_q[OPCODE_LSB];
              addr_stage_n[16] = rx_q[0];
              state_n          = ADDR_HI;
            end
            OP_WRITE_NEXT: begin
              is_read_n    = 1'b0;
              addr_stage_n = bus.bus_addr + ADDR_WIDTH'(1);
              state_n      = DATA;
            end
            default: begin // OP_READ_NEXT
              is_read_n    = 1'b1;
              addr_stage_n = bus.bus_addr + ADDR_WIDTH'(1);
              state_n      = ISSUE;
            end
          endcase
        end
      end
      ADDR_HI: if (byte_rdy) begin
        addr_stage_n[15:8] = rx_q;
        state_n            = ADDR_LO;
      end
      ADDR_LO: if (byte_rdy) begin
        addr_stage_n[7:0] = rx_q;
        state_n           = is_read ? ISSUE : DATA;
      end
      DATA: if (byte_rdy) begin
        data_stage_n = rx_q;
        state_n      = ISSUE;
      end
      ISSUE: state_n = WAIT;
      WAIT: if (bus.bus_done) begin
        busy_n    = 1'b0;
        if (is_read) spi_tx_n = bus.bus_rd_data;
        state_n   = (go_idle || cs_fall || cs_rise) ? IDLE : DONE;
        go_idle_n = 1'b0;
      end
      default: ; // DONE: bytes ignored until the next frame
    endcase

    // CS edges: a bus cycle in flight always completes; otherwise a falling
    // edge restarts parsing and a rising edge drops any partial command.
    if (state == ISSUE || (state == WAIT && !bus.bus_done)) begin
      if (cs_fall || cs_rise) go_idle_n = 1'b1;
    end else if (cs_fall) begin
      state_n = IDLE;
    end else if (cs_rise && state inside {ADDR_HI, ADDR_LO, DATA}) begin
      state_n = IDLE;
    end
    if (cs_fall) cmd_error_n = 1'b0;

    issue = (state_n == ISSUE);
    if (issue) busy_n = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cs_prev         <= 1'b1;
      valid_prev      <= 1'b0;
      rx_q            <= '0;
      byte_rdy        <= 1'b0;
      state           <= IDLE;
      is_read         <= 1'b0;
      go_idle         <= 1'b0;
      addr_stage      <= '0;
      data_stage      <= '0;
      spi_tx          <= '0;
      busy            <= 1'b0;
      cmd_error       <= 1'b0;
      bus.bus_addr    <= '0;
      bus.bus_wr_data <= '0;
      bus.bus_rw_n    <= 1'b1;
      bus.bus_strobe  <= 1'b0;
    end else begin
      cs_prev    <= cs_s;
      valid_prev <= valid_s;
      if (byte_evt) rx_q <= spi_rx;
      byte_rdy   <= byte_evt;
      state      <= state_n;
      is_read    <= is_read_n;
      go_idle    <= go_idle_n;
      addr_stage <= addr_stage_n;
      data_stage <= data_stage_n;
      spi_tx     <= spi_tx_n;
      busy       <= busy_n;
      cmd_error  <= cmd_error_n;
      // Request fields are loaded only on entry to ISSUE and then held through WAIT.
      bus.bus_strobe <= issue;
      if (issue) begin
        bus.bus_addr    <= addr_stage_n;
        bus.bus_wr_data <= data_stage_n;
        bus.bus_rw_n    <= is_read_n;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd.sv
// tb_spi_cmd: directed frames against spi_cmd. Expected bus requests are pushed
// into a queue as stimulus is issued; a monitor pops and compares on every
// bus_strobe. Status outputs are checked directly with check().
module tb_spi_cmd;
  import spi_cmd_pkg::*;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       spi_cs_n;
  logic       spi_valid;
  logic [7:0] spi_rx;
  logic [7:0] spi_tx;
  logic       busy;
  logic       cmd_error;

  spi_cmd_if #(.ADDR_WIDTH(17)) bus_if ();

  spi_cmd #(.ADDR_WIDTH(17), .SYNC_STAGES(2)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .spi_cs_n (spi_cs_n),
    .spi_valid(spi_valid),
    .spi_rx   (spi_rx),
    .spi_tx   (spi_tx),
    .busy     (busy),
    .cmd_error(cmd_error),
    .bus      (bus_if)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    logic        rw_n;
  } req_t;

  req_t exp_q[$];
  int   n_tests    = 0;
  int   n_fail     = 0;
  int   strobe_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected request.
  always @(negedge clk_sys) begin
    if (!reset && bus_if.bus_strobe === 1'b1) begin
      req_t e;
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got addr 0x%0h with empty queue", bus_if.bus_addr);
      end else begin
        e = exp_q.pop_front();
        check("strobe_addr", 32'(bus_if.bus_addr), 32'(e.addr));
        check("strobe_rw_n", 32'(bus_if.bus_rw_n), 32'(e.rw_n));
        if (!e.rw_n) check("strobe_wr_data", 32'(bus_if.bus_wr_data), 32'(e.data));
        check("strobe_busy", 32'(busy), 32'd1);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic push(input logic [16:0] a, input logic [7:0] d, input logic rw);
    req_t r;
    r.addr = a; r.data = d; r.rw_n = rw;
    exp_q.push_back(r);
  endtask

  task automatic frame_start();
    spi_cs_n = 1'b0;
    cycles(6);
  endtask

  task automatic frame_end();
    spi_cs_n = 1'b1;
    cycles(6);
  endtask

  // Valid high for 6 clk_sys cycles, low for 6: well inside an 8x SCLK byte.
  task automatic send_byte(input logic [7:0] b);
    spi_rx = b;
    cycles(1);
    spi_valid = 1'b1;
    cycles(6);
    spi_valid = 1'b0;
    cycles(6);
  endtask

  // Arbiter: waits (bounded) for busy, then returns done after a short latency.
  task automatic bus_respond(input logic [7:0] rd, input logic rd_cmd, input logic [7:0] tx_exp);
    int t = 0;
    while (busy !== 1'b1 && t < 50) begin
      cycles(1);
      t++;
    end
    check("busy_before_done", 32'(busy), 32'd1);
    cycles(2);
    bus_if.bus_done    = 1'b1;
    bus_if.bus_rd_data = rd;
    cycles(1);
    bus_if.bus_done    = 1'b0;
    bus_if.bus_rd_data = 8'h00;
    check("busy_after_done", 32'(busy), 32'd0);
    check(rd_cmd ? "spi_tx_read" : "spi_tx_write", 32'(spi_tx), 32'(tx_exp));
  endtask

  initial begin
    int s0;
    reset              = 1'b1;
    spi_cs_n           = 1'b1;
    spi_valid          = 1'b0;
    spi_rx             = 8'h00;
    bus_if.bus_done    = 1'b0;
    bus_if.bus_rd_data = 8'h00;
    cycles(3);

    // Reset values
    check("rst_spi_tx",    32'(spi_tx), 32'h0);
    check("rst_busy",      32'(busy), 32'h0);
    check("rst_cmd_error", 32'(cmd_error), 32'h0);
    check("rst_strobe",    32'(bus_if.bus_strobe), 32'h0);
    check("rst_rw_n",      32'(bus_if.bus_rw_n), 32'h1);
    check("rst_addr",      32'(bus_if.bus_addr), 32'h0);
    check("rst_wr_data",   32'(bus_if.bus_wr_data), 32'h0);
    check("rst_state",     32'(dut.state), 32'(IDLE));
    reset = 1'b0;
    cycles(4);

    // WRITE_AT 0x11234 <= 0x5A
    frame_start();
    push(17'h11234, 8'h5A, 1'b0);
    send_byte(8'h81); send_byte(8'h12); send_byte(8'h34); send_byte(8'h5A);
    check("wr_busy_held", 32'(busy), 32'd1);
    check("wr_addr_held", 32'(bus_if.bus_addr), 32'h11234);
    bus_respond(8'hEE, 1'b0, 8'h00);
    check("wr_state_done", 32'(dut.state), 32'(DONE));
    frame_end();

    // READ_AT 0x08000 -> 0xC3, then a dummy byte leaves spi_tx alone
    frame_start();
    push(17'h08000, 8'h00, 1'b1);
    send_byte(8'hA0); send_byte(8'h80); send_byte(8'h00);
    bus_respond(8'hC3, 1'b1, 8'hC3);
    send_byte(8'h00);
    check("rd_dummy_tx", 32'(spi_tx), 32'hC3);
    check("rd_state_done", 32'(dut.state), 32'(DONE));
    frame_end();

    // READ_AT 0x1FFFF, then READ_NEXT wraps to 0, then WRITE_NEXT to 1
    frame_start();
    push(17'h1FFFF, 8'h00, 1'b1);
    send_byte(8'hA1); send_byte(8'hFF); send_byte(8'hFF);
    bus_respond(8'h5E, 1'b1, 8'h5E);
    frame_end();
    frame_start();
    push(17'h00000, 8'h00, 1'b1);
    send_byte(8'hE0);
    bus_respond(8'h11, 1'b1, 8'h11);
    frame_end();
    frame_start();
    push(17'h00001, 8'h77, 1'b0);
    send_byte(8'hC0); send_byte(8'h77);
    bus_respond(8'h99, 1'b0, 8'h11);
    frame_end();

    // Aborted partial command, then illegal opcode
    s0 = strobe_cnt;
    frame_start();
    send_byte(8'h81); send_byte(8'h12);
    frame_end();
    check("abort_state_idle", 32'(dut.state), 32'(IDLE));
    check("abort_no_strobe", 32'(strobe_cnt), 32'(s0));
    frame_start();
    send_byte(8'h3F);
    check("illegal_err", 32'(cmd_error), 32'd1);
    check("illegal_state", 32'(dut.state), 32'(DONE));
    frame_end();
    check("illegal_sticky", 32'(cmd_error), 32'd1);
    check("illegal_no_strobe", 32'(strobe_cnt), 32'(s0));
    frame_start();
    check("err_cleared", 32'(cmd_error), 32'd0);
    frame_end();

    // CS released during WAIT plus a stray byte: one strobe, then IDLE
    s0 = strobe_cnt;
    frame_start();
    push(17'h00042, 8'h00, 1'b1);
    send_byte(8'hA0); send_byte(8'h00); send_byte(8'h42);
    frame_end();
    send_byte(8'h81);
    check("wait_state_held", 32'(dut.state), 32'(WAIT));
    check("wait_one_strobe", 32'(strobe_cnt), 32'(s0 + 1));
    bus_respond(8'h99, 1'b1, 8'h99);
    check("wait_then_idle", 32'(dut.state), 32'(IDLE));

    // Reset in WAIT, then a late bus_done
    s0 = strobe_cnt;
    frame_start();
    push(17'h00043, 8'h00, 1'b1);
    send_byte(8'hE0);
    check("rst_wait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    cycles(1);
    check("rstw_spi_tx", 32'(spi_tx), 32'h0);
    check("rstw_busy",   32'(busy), 32'h0);
    check("rstw_addr",   32'(bus_if.bus_addr), 32'h0);
    check("rstw_rw_n",   32'(bus_if.bus_rw_n), 32'h1);
    reset = 1'b0;
    cycles(1);
    bus_if.bus_done    = 1'b1;
    bus_if.bus_rd_data = 8'hAA;
    cycles(1);
    bus_if.bus_done    = 1'b0;
    bus_if.bus_rd_data = 8'h00;
    cycles(2);
    check("rstw_tx_after_done", 32'(spi_tx), 32'h0);
    check("rstw_state", 32'(dut.state), 32'(IDLE));
    check("rstw_strobe_cnt", 32'(strobe_cnt), 32'(s0 + 1));
    frame_end();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
